// File: rtl/dma_rd_tag_mgr.sv
// ============================================================================
// Module   : dma_rd_tag_mgr
// Brief    : DMA read-tag allocator (lowest free tag first) with flush/drain
//            handshake. Optional double-free checker: DMA_TAG_CHK_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dma_rd_tag_mgr #(
  parameter int TAG_NUM = 64,
  parameter int TAG_LOG = 6
) (
  input  logic               dma_clk,
  input  logic               rst_n,
  output logic               o_alloc_valid,
  output logic [TAG_LOG-1:0] o_alloc_tag,
  input  logic               i_alloc_ready,
  input  logic               i_rel_valid,
  input  logic [TAG_LOG-1:0] i_rel_tag,
  input  logic               i_flush_req,
  output logic               o_flush_done,
  output logic [TAG_LOG:0]   o_used_cnt,
  output logic               o_err_double_free
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [TAG_NUM-1:0]   r_free_vec;
  logic [TAG_NUM-1:0]   w_free_nxt;
  logic [TAG_LOG:0]     r_used_cnt;
  logic [TAG_LOG:0]     w_used_nxt;
  logic [TAG_LOG-1:0]   w_lowest;
  logic                 w_alloc_fire;
  logic                 w_rel_dec;

  // Scan from the top so the last hit is the lowest set bit.
  always_comb begin
    w_lowest = '0;
    for (int i = TAG_NUM - 1; i >= 0; i--) begin
      if (r_free_vec[i]) w_lowest = TAG_LOG'(i);
    end
  end

  assign o_alloc_tag   = w_lowest;
  assign o_alloc_valid = (r_state == ST_RUN) && (|r_free_vec);
  assign o_flush_done  = (r_state == ST_DONE);
  assign o_used_cnt    = r_used_cnt;
  assign w_alloc_fire  = o_alloc_valid & i_alloc_ready;

`ifdef DMA_TAG_CHK_EN
  logic w_rel_illegal;
  logic r_err;

  assign w_rel_illegal = i_rel_valid & (r_free_vec[i_rel_tag] | (r_used_cnt == '0));
  assign w_rel_dec     = i_rel_valid & ~w_rel_illegal;

  always_ff @(posedge dma_clk or negedge rst_n) begin
    if (!rst_n)             r_err <= 1'b0;
    else if (w_rel_illegal) r_err <= 1'b1;
  end

  assign o_err_double_free = r_err;
`else
  assign w_rel_dec         = i_rel_valid & (r_used_cnt != '0);
  assign o_err_double_free = 1'b0;
`endif

  // Allocation is applied after release so that a same-tag collision leaves the tag taken.
  always_comb begin
    w_free_nxt = r_free_vec;
    if (i_rel_valid)  w_free_nxt[i_rel_tag] = 1'b1;
    if (w_alloc_fire) w_free_nxt[w_lowest]  = 1'b0;
  end

  always_comb begin
    w_used_nxt = r_used_cnt;
    case ({w_alloc_fire, w_rel_dec})
      2'b10:   w_used_nxt = r_used_cnt + 1'b1;
      2'b01:   w_used_nxt = r_used_cnt - 1'b1;
      default: w_used_nxt = r_used_cnt;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN:   if (i_flush_req)        w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (w_used_nxt == '0)   w_state_nxt = ST_DONE;
      ST_DONE:  w_state_nxt = i_flush_req ? ST_HOLD : ST_RUN;
      ST_HOLD:  if (!i_flush_req)       w_state_nxt = ST_RUN;
      default:  w_state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge dma_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_RUN;
      r_free_vec <= '1;
      r_used_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_free_vec <= w_free_nxt;
      r_used_cnt <= w_used_nxt;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dma_rd_tag_mgr.sv
// ============================================================================
// Module   : tb_dma_rd_tag_mgr
// Brief    : Self-checking bench for dma_rd_tag_mgr with an expected-tag queue.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dma_rd_tag_mgr;

  localparam int TAG_NUM = 64;
  localparam int TAG_LOG = 6;

`ifdef DMA_TAG_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic               dma_clk;
  logic               rst_n;
  logic               o_alloc_valid;
  logic [TAG_LOG-1:0] o_alloc_tag;
  logic               i_alloc_ready;
  logic               i_rel_valid;
  logic [TAG_LOG-1:0] i_rel_tag;
  logic               i_flush_req;
  logic               o_flush_done;
  logic [TAG_LOG:0]   o_used_cnt;
  logic               o_err_double_free;

  int tests;
  int fails;
  logic [TAG_LOG-1:0] exp_q[$];
  logic [TAG_LOG-1:0] exp_tag;

  dma_rd_tag_mgr #(.TAG_NUM(TAG_NUM), .TAG_LOG(TAG_LOG)) u_dut (
    .dma_clk           (dma_clk),
    .rst_n             (rst_n),
    .o_alloc_valid     (o_alloc_valid),
    .o_alloc_tag       (o_alloc_tag),
    .i_alloc_ready     (i_alloc_ready),
    .i_rel_valid       (i_rel_valid),
    .i_rel_tag         (i_rel_tag),
    .i_flush_req       (i_flush_req),
    .o_flush_done      (o_flush_done),
    .o_used_cnt        (o_used_cnt),
    .o_err_double_free (o_err_double_free)
  );

  initial dma_clk = 1'b0;
  always #5 dma_clk = ~dma_clk;

  // Inputs are driven and outputs sampled on the falling edge.
  task automatic step();
    @(negedge dma_clk);
  endtask

  task automatic do_reset();
    i_alloc_ready = 0; i_rel_valid = 0; i_rel_tag = '0; i_flush_req = 0;
    rst_n = 0;
    step(); step();
    rst_n = 1;
    step();
  endtask

  task automatic alloc_n(input int n);
    int cnt = 0;
    int cyc = 0;
    while (cnt < n && cyc < 400) begin
      if (o_alloc_valid) begin i_alloc_ready = 1; cnt++; end
      else i_alloc_ready = 0;
      step(); cyc++;
    end
    i_alloc_ready = 0;
    tests++;
    if (cnt != n) begin fails++; $display("FAIL alloc_n_timeout: granted %0d need %0d", cnt, n); end
  endtask

  task automatic release_one(input int tag);
    i_rel_valid = 1; i_rel_tag = TAG_LOG'(tag);
    step();
    i_rel_valid = 0;
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (o_alloc_valid !== 1'b1) begin fails++; $display("FAIL rst_alloc_valid: got %b exp 1", o_alloc_valid); end
    tests++; if (o_alloc_tag !== '0) begin fails++; $display("FAIL rst_alloc_tag: got %0d exp 0", o_alloc_tag); end
    tests++; if (o_used_cnt !== '0) begin fails++; $display("FAIL rst_used_cnt: got %0d exp 0", o_used_cnt); end
    tests++; if (o_flush_done !== 1'b0) begin fails++; $display("FAIL rst_flush_done: got %b exp 0", o_flush_done); end
    tests++; if (o_err_double_free !== 1'b0) begin fails++; $display("FAIL rst_err: got %b exp 0", o_err_double_free); end
  endtask

  task automatic test_back_to_back();
    int cyc = 0;
    for (int i = 0; i < TAG_NUM; i++) exp_q.push_back(TAG_LOG'(i));
    i_alloc_ready = 1;
    while (exp_q.size() > 0 && cyc < 200) begin
      if (o_alloc_valid) begin
        exp_tag = exp_q.pop_front();
        tests++;
        if (o_alloc_tag !== exp_tag) begin fails++; $display("FAIL grant_order: got %0d exp %0d", o_alloc_tag, exp_tag); end
      end
      step(); cyc++;
    end
    i_alloc_ready = 0;
    tests++;
    if (cyc != TAG_NUM) begin fails++; $display("FAIL grant_rate: took %0d cycles exp %0d", cyc, TAG_NUM); end
    exp_q.delete();
    tests++; if (o_used_cnt !== 7'd64) begin fails++; $display("FAIL full_used_cnt: got %0d exp 64", o_used_cnt); end
    tests++; if (o_alloc_valid !== 1'b0) begin fails++; $display("FAIL full_alloc_valid: got %b exp 0", o_alloc_valid); end
  endtask

  task automatic test_release_reoffer();
    exp_q.push_back(TAG_LOG'(17));
    release_one(17);
    exp_tag = exp_q.pop_front();
    tests++; if (o_alloc_valid !== 1'b1) begin fails++; $display("FAIL reoffer_valid: got %b exp 1", o_alloc_valid); end
    tests++; if (o_alloc_tag !== exp_tag) begin fails++; $display("FAIL reoffer_tag: got %0d exp %0d", o_alloc_tag, exp_tag); end
    tests++; if (o_used_cnt !== 7'd63) begin fails++; $display("FAIL reoffer_used: got %0d exp 63", o_used_cnt); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    alloc_n(41);
    for (int t = 3; t <= 33; t++) release_one(t);
    exp_q.push_back(TAG_LOG'(3));
    exp_q.push_back(TAG_LOG'(4));
    tests++; if (o_used_cnt !== 7'd10) begin fails++; $display("FAIL simul_pre_used: got %0d exp 10", o_used_cnt); end
    exp_tag = exp_q.pop_front();
    tests++; if (o_alloc_tag !== exp_tag) begin fails++; $display("FAIL simul_pre_tag: got %0d exp %0d", o_alloc_tag, exp_tag); end
    i_alloc_ready = 1; i_rel_valid = 1; i_rel_tag = TAG_LOG'(40);
    step();
    i_alloc_ready = 0; i_rel_valid = 0;
    exp_tag = exp_q.pop_front();
    tests++; if (o_used_cnt !== 7'd10) begin fails++; $display("FAIL simul_used: got %0d exp 10", o_used_cnt); end
    tests++; if (o_alloc_tag !== exp_tag) begin fails++; $display("FAIL simul_tag: got %0d exp %0d", o_alloc_tag, exp_tag); end
  endtask

  task automatic test_flush();
    do_reset();
    alloc_n(2);
    i_flush_req = 1;
    step();
    tests++; if (o_alloc_valid !== 1'b0) begin fails++; $display("FAIL flush_drop_valid: got %b exp 0", o_alloc_valid); end
    release_one(0);
    tests++; if (o_flush_done !== 1'b0) begin fails++; $display("FAIL flush_early_done: got %b exp 0", o_flush_done); end
    release_one(1);
    tests++; if (o_flush_done !== 1'b1) begin fails++; $display("FAIL flush_done_pulse: got %b exp 1", o_flush_done); end
    step();
    tests++; if (o_flush_done !== 1'b0) begin fails++; $display("FAIL flush_done_width: got %b exp 0", o_flush_done); end
    step();
    tests++; if (o_alloc_valid !== 1'b0) begin fails++; $display("FAIL flush_hold_valid: got %b exp 0", o_alloc_valid); end
    i_flush_req = 0;
    step();
    tests++; if (o_alloc_valid !== 1'b1) begin fails++; $display("FAIL flush_resume_valid: got %b exp 1", o_alloc_valid); end
  endtask

  task automatic test_flush_empty();
    i_flush_req = 1;
    step();
    tests++; if (o_flush_done !== 1'b0) begin fails++; $display("FAIL empty_drain_done: got %b exp 0", o_flush_done); end
    step();
    i_flush_req = 0;
    tests++; if (o_flush_done !== 1'b1) begin fails++; $display("FAIL empty_done_pulse: got %b exp 1", o_flush_done); end
    step();
    tests++; if (o_flush_done !== 1'b0) begin fails++; $display("FAIL empty_done_width: got %b exp 0", o_flush_done); end
    tests++; if (o_alloc_valid !== 1'b1) begin fails++; $display("FAIL empty_resume_valid: got %b exp 1", o_alloc_valid); end
  endtask

  task automatic test_double_free();
    do_reset();
    release_one(5);
    tests++; if (o_used_cnt !== '0) begin fails++; $display("FAIL dfree_used0: got %0d exp 0", o_used_cnt); end
    tests++; if (o_err_double_free !== CHK) begin fails++; $display("FAIL dfree_err: got %b exp %b", o_err_double_free, CHK); end
    alloc_n(1);
    release_one(5);
    tests++;
    if (o_used_cnt !== (CHK ? 7'd1 : 7'd0)) begin
      fails++; $display("FAIL dfree_used1: got %0d exp %0d", o_used_cnt, CHK ? 1 : 0);
    end
    step();
    tests++; if (o_err_double_free !== CHK) begin fails++; $display("FAIL dfree_sticky: got %b exp %b", o_err_double_free, CHK); end
  endtask

  task automatic test_async_reset();
    do_reset();
    alloc_n(3);
    i_flush_req = 1;
    step();
    #2 rst_n = 0;
    #1;
    tests++; if (o_used_cnt !== '0) begin fails++; $display("FAIL arst_used: got %0d exp 0", o_used_cnt); end
    tests++; if (o_alloc_valid !== 1'b1 || o_alloc_tag !== '0) begin
      fails++; $display("FAIL arst_alloc: got valid=%b tag=%0d exp valid=1 tag=0", o_alloc_valid, o_alloc_tag);
    end
    i_flush_req = 0;
    step();
    rst_n = 1;
    step();
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_back_to_back();
    test_release_reoffer();
    test_simultaneous();
    test_flush();
    test_flush_empty();
    test_double_free();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dma_rd_tag_mgr.md
# dma_rd_tag_mgr

Tag allocator and drain controller for the DMA read path. It hands out read-request tags to the request generator and reclaims each tag when the read-response dealignment stage forwards the final beat of the last sub-response for that tag. That beat has eop asserted and is accepted by the reorder buffer. The block bounds outstanding reads to the reorder buffer capacity and provides a flush handshake that lets software or the DMA control path quiesce the read datapath.

## Interface
Parameters:
- TAG_NUM, 64, number of tags; equals reorder buffer slots; power of two, 2..256
- TAG_LOG, 6, log2(TAG_NUM)

Ports:
- dma_clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- alloc_valid  out  1  a tag is available for allocation
- alloc_tag  out  TAG_LOG  tag offered; lowest-index free tag
- alloc_ready  in  1  requester takes alloc_tag this cycle
- rel_valid  in  1  driven by rd_rsp_dealign_valid & rd_rsp_dealign_ready & rd_rsp_dealign_eop
- rel_tag  in  TAG_LOG  rd_rsp_dealign_tag of the releasing beat
- flush_req  in  1  level; request drain of all outstanding tags
- flush_done  out  1  one-cycle pulse: all tags free, drain complete
- used_cnt  out  TAG_LOG+1  number of tags currently outstanding
- err_double_free  out  1  sticky: release of a tag that was not outstanding

## Operation
- State: free_vec[TAG_NUM-1:0] register, where bit=1 means free. Reset value is all ones.
- alloc_tag = index of the lowest set bit of free_vec; 0 when none is set.
- Allocation fires on alloc_valid & alloc_ready. free_vec[alloc_tag] clears on the next edge and used_cnt increments.
- Release on rel_valid sets free_vec[rel_tag] on the next edge and decrements used_cnt.
- Simultaneous allocate and release: both apply in the same edge and used_cnt is unchanged. A same-tag collision cannot occur legally, because a released tag is outstanding and therefore not free. If it does occur with the checker on, the release is flagged and the allocate wins.
- FSM, with reset state RUN:
  - RUN: alloc_valid = |free_vec. When flush_req=1, go to DRAIN.
  - DRAIN: alloc_valid=0 and releases continue. When used_cnt==0, or when it reaches 0 on this edge, go to DONE.
  - DONE: flush_done=1 for exactly this one cycle and alloc_valid=0. If flush_req is still 1, go to HOLD; otherwise go to RUN.
  - HOLD: alloc_valid=0. When flush_req=0, go to RUN.
- Entering DRAIN with used_cnt already 0 still passes through DONE, so flush_done is always pulsed.
- used_cnt is never allowed to wrap. An allocation is impossible when used_cnt==TAG_NUM because free_vec is all zero. A release is ignored when used_cnt==0 (checker flags it).

## Timing
- Reset values: alloc_valid=1, alloc_tag=0, used_cnt=0, flush_done=0, err_double_free=0, state RUN.
- alloc_valid and alloc_tag are combinational from registers only. There is no combinational path from alloc_ready or rel_*.
- A released tag is re-offerable on the cycle after rel_valid, giving 1-cycle release latency.
- An allocated tag disappears from alloc_tag on the cycle after acceptance. Back-to-back allocations at one per cycle are supported.
- alloc_valid drops in the cycle after flush_req is sampled. The last grant can occur in the same cycle that flush_req first rises.
- Asynchronous reset mid-operation returns every tag to free and discards the drain. The requester and response path must be reset together with this block.

## Configuration
- DMA_TAG_CHK_EN defined: a release of a tag whose free_vec bit is already 1, or a release while used_cnt==0, sets err_double_free (sticky until reset). That release leaves used_cnt unchanged.
- DMA_TAG_CHK_EN undefined: no check is made and err_double_free is tied to 0. An illegal release still sets the bit, and used_cnt is decremented only if it is nonzero.

## Test plan
- Reset, then hold alloc_ready=1 for 64 cycles:
  - tags 0,1,...,63 are granted in order;
  - used_cnt=64 and alloc_valid=0 on cycle 65.
- With all tags used, pulse rel_valid with rel_tag=17 → next cycle alloc_valid=1 and alloc_tag=17.
- Simultaneous alloc (tag 3) and release (tag 40) with used_cnt=10 → used_cnt stays 10, and alloc_tag shows 4 the next cycle (tags 0-2 busy).
- With used_cnt=2, raise flush_req → alloc_valid=0 next cycle. After releases of both tags, flush_done pulses once and the FSM sits in HOLD until flush_req=0, then RUN with alloc_valid=1.
- flush_req with used_cnt=0 → flush_done pulses 2 cycles after flush_req rises (DRAIN then DONE).
- With DMA_TAG_CHK_EN, release free tag 5 → err_double_free=1 (sticky) and used_cnt unchanged. Without the macro, err_double_free stays 0.
